// File: rtl/color_fader_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : color_fader_mc                                             |
// | Description : Multi-channel linear colour fader. A request latches the   |
// |               current colour as start and in_color as target, then steps |
// |               a frame index k from 0 to NUM_FRAMES once every            |
// |               FRAME_CYCLES clocks. Each channel shows                    |
// |               start + trunc((target - start) * k / NUM_FRAMES). A snap   |
// |               request jumps straight to the target.                      |
// | Option      : FADER_RETARGET_EN - when defined, requests are also        |
// |               accepted mid-fade and restart from the live colour.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module color_fader_mc #(
  parameter int NUM_CH       = 3,
  parameter int CH_W         = 8,
  parameter int FRAME_CYCLES = 5_000_000,
  parameter int NUM_FRAMES   = 30
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*CH_W-1:0]   in_color,
  input  logic                     in_snap,
  output logic [NUM_CH*CH_W-1:0]   color_out,
  output logic                     busy,
  output logic                     done
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_FADE = 1'b1;

  // Frame-cycle counter width; a 1-cycle frame still needs one bit.
  localparam int c_CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_CYC_LAST = c_CW'(FRAME_CYCLES - 1);
  localparam logic [c_CW-1:0] c_CYC_ONE  = c_CW'(1);

  localparam logic [7:0] c_NF    = 8'(NUM_FRAMES);
  localparam logic [7:0] c_NF_M1 = 8'(NUM_FRAMES - 1);

  // Interpolation arithmetic width: signed delta (CH_W+1) times an 8-bit k.
  localparam int c_PW = CH_W + 10;
  localparam logic signed [c_PW-1:0] c_NF_S = c_PW'(NUM_FRAMES);

  logic [0:0]              r_state;
  logic [NUM_CH*CH_W-1:0]  r_start;
  logic [NUM_CH*CH_W-1:0]  r_target;
  logic [7:0]              r_k;
  logic [c_CW-1:0]         r_cyc;
  logic                    r_done;

  logic                    w_accept;

`ifdef FADER_RETARGET_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = (r_state == c_IDLE);
`endif

  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state == c_FADE);
  assign done     = r_done;

  // Per-channel interpolation. Signed division truncates toward zero, so a
  // down-fade never undershoots the target and the sum stays in range.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic        [CH_W-1:0] w_st;
      logic        [CH_W-1:0] w_tg;
      logic signed [CH_W:0]   w_delta;
      logic signed [c_PW-1:0] w_delta_x;
      logic signed [c_PW-1:0] w_k_x;
      logic signed [c_PW-1:0] w_start_x;
      logic signed [c_PW-1:0] w_prod;

      assign w_st      = r_start[gi*CH_W +: CH_W];
      assign w_tg      = r_target[gi*CH_W +: CH_W];
      assign w_delta   = $signed({1'b0, w_tg}) - $signed({1'b0, w_st});
      assign w_delta_x = $signed({{(c_PW-CH_W-1){w_delta[CH_W]}}, w_delta});
      assign w_k_x     = $signed({{(c_PW-8){1'b0}}, r_k});
      assign w_start_x = $signed({{(c_PW-CH_W){1'b0}}, w_st});
      assign w_prod    = w_delta_x * w_k_x;
      assign color_out[gi*CH_W +: CH_W] = CH_W'(w_start_x + (w_prod / c_NF_S));
    end
  endgenerate

  // Request acceptance, frame stepping and completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= c_IDLE;
      r_start  <= '0;
      r_target <= '0;
      r_k      <= c_NF;
      r_cyc    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // A new request always wins, including on the would-be final edge.
        r_start  <= color_out;
        r_target <= in_color;
        r_cyc    <= '0;
        if (in_snap) begin
          r_k     <= c_NF;
          r_state <= c_IDLE;
          r_done  <= 1'b1;
        end else begin
          r_k     <= 8'd0;
          r_state <= c_FADE;
        end
      end else if (r_state == c_FADE) begin
        if (r_cyc == c_CYC_LAST) begin
          r_cyc <= '0;
          r_k   <= r_k + 8'd1;
          if (r_k == c_NF_M1) begin
            r_state <= c_IDLE;
            r_done  <= 1'b1;
          end
        end else begin
          r_cyc <= r_cyc + c_CYC_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_color_fader_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_color_fader_mc                                          |
// | Description : Self-checking bench for color_fader_mc (3 x 8-bit channels,|
// |               4-cycle frames, 4 frames per fade). Directed table rows    |
// |               plus random requests checked against a time-based model.   |
// | Option      : FADER_RETARGET_EN selects the retargeting expectations.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_color_fader_mc;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int FC  = 4;
  localparam int NF  = 4;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_color;
  logic        in_snap;
  logic [23:0] color_out;
  logic        busy;
  logic        done;

  color_fader_mc #(
    .NUM_CH(NCH), .CH_W(CW), .FRAME_CYCLES(FC), .NUM_FRAMES(NF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_color(in_color), .in_snap(in_snap), .color_out(color_out),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: fade described by start/target and elapsed cycles.
  logic [23:0] m_start;
  logic [23:0] m_target;
  bit          m_active;
  int          m_el;
  bit          m_done;
  bit          last_acc;

  function automatic logic [23:0] m_color();
    logic [23:0] r;
    int k, s, t, v;
    k = m_active ? (m_el / FC) : NF;
    if (k > NF) k = NF;
    r = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      s = int'(m_start[ch*8 +: 8]);
      t = int'(m_target[ch*8 +: 8]);
      v = s + ((t - s) * k) / NF;
      r[ch*8 +: 8] = 8'(v);
    end
    return r;
  endfunction

  function automatic bit m_ready();
`ifdef FADER_RETARGET_EN
    return 1'b1;
`else
    return !m_active;
`endif
  endfunction

  task automatic m_reset();
    m_start = '0; m_target = '0; m_active = 0; m_el = 0; m_done = 0;
  endtask

  task automatic m_edge(input bit acc, input logic [23:0] c, input bit s);
    m_done = 0;
    if (acc) begin
      m_start  = m_color();
      m_target = c;
      if (s) begin
        m_active = 0;
        m_done   = 1;
      end else begin
        m_active = 1;
        m_el     = 0;
      end
    end else if (m_active) begin
      m_el++;
      if (m_el == NF * FC) begin
        m_active = 0;
        m_done   = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare #1 later.
  task automatic step(input logic v, input logic [23:0] c, input logic s);
    bit acc;
    in_valid = v; in_color = c; in_snap = s;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
    acc = v && m_ready();
    @(posedge clk);
    m_edge(acc, c, s);
    last_acc = acc;
    #1;
    chk("color_out", {8'd0, color_out}, {8'd0, m_color()});
    chk("busy", {31'd0, busy}, {31'd0, m_active});
    chk("done", {31'd0, done}, {31'd0, m_done});
  endtask

  typedef struct {
    logic        v;
    logic [23:0] c;
    logic        s;
    logic [23:0] eo;
    logic        eb;
    logic        ed;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [23:0] c, input logic s,
                     input logic [23:0] eo, input logic eb, input logic ed);
    vec_t r;
    r.v = v; r.c = c; r.s = s; r.eo = eo; r.eb = eb; r.ed = ed;
    tbl.push_back(r);
  endtask

  initial begin
    logic [7:0] r0 [5];
    logic [7:0] r1 [5];
    logic [7:0] r2 [5];
    logic [31:0] rnd;
    int ndone;

    r0 = '{8'h00, 8'h3F, 8'h7F, 8'hBF, 8'hFF};
    r1 = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80};
    r2 = '{8'hFF, 8'hC0, 8'h80, 8'h40, 8'h00};

    // Up-fade from 0 to 0x0080FF; idle rows carry junk on in_color/in_snap.
    add(1'b1, 24'h0080FF, 1'b0, 24'h000000, 1'b1, 1'b0);
    for (int j = 1; j <= 16; j++)
      add(1'b0, 24'hA5A5A5, 1'b1, {8'h00, r1[j/4], r0[j/4]}, j < 16, j == 16);
    add(1'b0, 24'h5A5A5A, 1'b1, 24'h0080FF, 1'b0, 1'b0);
    // Snap to 0xFF0000, then down-fade to black.
    add(1'b1, 24'hFF0000, 1'b1, 24'hFF0000, 1'b0, 1'b1);
    add(1'b0, 24'h000000, 1'b0, 24'hFF0000, 1'b0, 1'b0);
    add(1'b1, 24'h000000, 1'b0, 24'hFF0000, 1'b1, 1'b0);
    for (int j = 1; j <= 16; j++)
      add(1'b0, 24'h3C3C3C, 1'b0, {r2[j/4], 16'h0000}, j < 16, j == 16);
    // Snap to 0x123456.
    add(1'b1, 24'h123456, 1'b1, 24'h123456, 1'b0, 1'b1);
    add(1'b0, 24'h000000, 1'b0, 24'h123456, 1'b0, 1'b0);

    // Reset values.
    in_valid = 1'b0; in_color = '0; in_snap = 1'b0;
    reset_n = 1'b0;
    m_reset();
    #13;
    chk("rst color_out", {8'd0, color_out}, 32'h0);
    chk("rst busy", {31'd0, busy}, 32'h0);
    chk("rst done", {31'd0, done}, 32'h0);
    chk("rst in_ready", {31'd0, in_ready}, 32'h1);
    #14 reset_n = 1'b1;

    // Directed table.
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].c, tbl[i].s);
      chk($sformatf("tbl%0d color", i), {8'd0, color_out}, {8'd0, tbl[i].eo});
      chk($sformatf("tbl%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].eb});
      chk($sformatf("tbl%0d done", i), {31'd0, done}, {31'd0, tbl[i].ed});
    end

    // Request during a fade: blocked until idle, or retargets mid-fade.
    ndone = 0;
    step(1'b1, 24'hFFFFFF, 1'b0);
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 24'h0, 1'b0);
      ndone += int'(done);
    end
    begin
      bit pend;
      pend = 1'b1;
      for (int j = 0; j < 45; j++) begin
        step(pend, 24'h00FF00, 1'b0);
        if (last_acc) pend = 1'b0;
        ndone += int'(done);
      end
      chk("held req accepted", {31'd0, pend}, 32'h0);
    end
`ifdef FADER_RETARGET_EN
    chk("done count retarget", ndone, 1);
`else
    chk("done count queued", ndone, 2);
`endif
    chk("final colour", {8'd0, color_out}, 32'h0000FF00);

    // Reset in the middle of a fade.
    step(1'b1, 24'h808080, 1'b0);
    for (int j = 0; j < 5; j++) step(1'b0, 24'h0, 1'b0);
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    chk("midrst color_out", {8'd0, color_out}, 32'h0);
    chk("midrst busy", {31'd0, busy}, 32'h0);
    chk("midrst done", {31'd0, done}, 32'h0);
    chk("midrst in_ready", {31'd0, in_ready}, 32'h1);
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      chk("midrst no done", {31'd0, done}, 32'h0);
    end
    #2 reset_n = 1'b1;
    // First request after reset fades from black.
    step(1'b1, 24'h404040, 1'b0);
    for (int j = 0; j < 4; j++) step(1'b0, 24'h0, 1'b0);
    chk("post-rst k1", {8'd0, color_out}, 32'h00101010);

    // Random requests against the model.
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom;
      step($urandom_range(0, 9) == 0, rnd[23:0], $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
